mem_arbiter: RTL and testbench

Sequential arbiter that shares the single RAM port between the instruction-fetch path (icache side of `datapath_cache_if`, driven by `program_counter`) and the data-memory path. It registers a grant, forwards the granted requester's address/data/enables to RAM, holds the requester in wait until RAM reports `ACCESS`, and then releases the grant. Data requests have priority, with a bounded-starvation rule so instruction fetch always progresses. Sits between the cache interfaces and `cpu_ram_if`.

---
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between instruction fetch and data memory.
// Data requests normally win. A starvation counter forces an instruction grant
// after STARVE_MAX consecutive data grants made while a fetch was waiting.
// Only the grant state and the starvation counter are registered. Every RAM
// output and every wait is decoded combinationally from them.

module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  // instruction side
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  // data side
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  // ram side
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  // Encoding matches ramstate_t in cpu_types_pkg.
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

  state_t        state, nstate;
  logic [SW-1:0] scnt, nscnt;
  ramstate_t     rstat;

  logic dreq;
  logic ireq;
  logic ramdone;
  logic ramerr;
  logic starved;
  logic ddone;
  logic idone;
  logic ddrop;
  logic idrop;

  assign rstat   = ramstate_t'(ramstate);
  assign dreq    = dREN | dWEN;
  assign ireq    = iREN;
  assign ramdone = (rstat == ACCESS);
  assign ramerr  = (rstat == ERROR);
  assign starved = (scnt == SMAX);

  // A completion is reported only while the granted requester is still asking.
  // If the requester drops its enables, the grant is abandoned and no
  // completion is reported.
  assign ddone = (state == DGNT) & dreq & ramdone;
  assign idone = (state == IGNT) & ireq & ramdone;
  assign ddrop = (state == DGNT) & ~dreq;
  assign idrop = (state == IGNT) & ~ireq;

  // State and starvation counter. Reset returns to IDLE at once, which pulls
  // the RAM enables low without waiting for a clock edge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      scnt  <= '0;
    end else begin
      state <= nstate;
      scnt  <= nscnt;
    end
  end

  // Next grant. Each grant runs until completion, error or requester drop and
  // then always passes through IDLE, so one access takes at least two cycles.
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: begin
        if (dreq && ireq && starved) begin
          nstate = IGNT;
        end else if (dreq) begin
          nstate = DGNT;
        end else if (ireq) begin
          nstate = IGNT;
        end else begin
          nstate = IDLE;
        end
      end
      DGNT: begin
        if (ddrop || ramdone || ramerr) begin
          nstate = IDLE;
        end
      end
      IGNT: begin
        if (idrop || ramdone || ramerr) begin
          nstate = IDLE;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  // The counter counts data completions that happened while a fetch was
  // pending. It saturates at STARVE_MAX. A fetch completion clears it, and so
  // does a data completion with no fetch waiting. Errors and drops leave it
  // unchanged.
  always_comb begin
    nscnt = scnt;
    if (ddone) begin
      if (ireq) begin
        nscnt = starved ? scnt : scnt + 1'b1;
      end else begin
        nscnt = '0;
      end
    end else if (idone) begin
      nscnt = '0;
    end
  end

  // RAM port and waits decoded from the current grant. When both data enables
  // are high, the write wins.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    unique case (state)
      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dwait    = ~ddone;
      end
      IGNT: begin
        ramaddr  = iaddr;
        ramREN   = iREN;
        iwait    = ~idone;
      end
      default: begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
      end
    endcase
  end

  // Read data goes straight through to both sides. It is meaningful only in
  // the owner's completion cycle.
  assign iload = ramload;
  assign dload = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with STARVE_MAX = 4.
// The bench drives ramstate directly, acting as the RAM, and checks the
// combinational outputs a couple of time units after each rising edge.

module tb_mem_arbiter;

  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  int passCount;
  int failCount;
  int checkCount;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  // 10-unit clock period
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Backstop so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive every input at once, then let the combinational outputs settle
  task automatic applyStimulus(input logic reqI, input logic [31:0] addrI,
                               input logic reqDR, input logic reqDW,
                               input logic [31:0] addrD, input logic [31:0] storeD,
                               input logic [1:0] rs, input logic [31:0] rl);
    iREN     = reqI;
    iaddr    = addrI;
    dREN     = reqDR;
    dWEN     = reqDW;
    daddr    = addrD;
    dstore   = storeD;
    ramstate = rs;
    ramload  = rl;
    #1;
  endtask

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [9:0] grantIsI;
    passCount  = 0;
    failCount  = 0;
    checkCount = 0;
    grantIsI   = 10'b10_0001_0000;

    // ---- reset, then idle ----
    nRST = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, RS_FREE, 32'h0);
    #3;
    checkOutput("rst_iwait",   32'(iwait),  32'd1);
    checkOutput("rst_dwait",   32'(dwait),  32'd1);
    checkOutput("rst_ramREN",  32'(ramREN), 32'd0);
    checkOutput("rst_ramWEN",  32'(ramWEN), 32'd0);
    checkOutput("rst_ramaddr", ramaddr,     32'h0);
    tick();
    nRST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("idle_iwait", 32'(iwait), 32'd1);
      checkOutput("idle_dwait", 32'(dwait), 32'd1);
      checkOutput("idle_ramen", 32'(ramREN | ramWEN), 32'd0);
    end
    $display("[TB] reset/idle done");

    // ---- single fetch ----
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, RS_FREE, 32'h0);
    checkOutput("fetch_arb_ramREN", 32'(ramREN), 32'd0);
    tick();
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, RS_BUSY, 32'h0);
    checkOutput("fetch_ramREN",  32'(ramREN), 32'd1);
    checkOutput("fetch_ramaddr", ramaddr,     32'h40);
    checkOutput("fetch_busy_iwait", 32'(iwait), 32'd1);
    tick();
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, RS_ACCESS, 32'hDEADBEEF);
    checkOutput("fetch_done_iwait", 32'(iwait), 32'd0);
    checkOutput("fetch_iload",      iload,      32'hDEADBEEF);
    checkOutput("fetch_done_dwait", 32'(dwait), 32'd1);
    tick();
    applyStimulus(1'b0, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, RS_FREE, 32'h0);
    checkOutput("fetch_after_iwait", 32'(iwait), 32'd1);
    checkOutput("fetch_after_addr",  ramaddr,    32'h0);

    // ---- simultaneous requests: data first ----
    applyStimulus(1'b1, 32'h44, 1'b0, 1'b1, 32'h80, 32'h1234, RS_FREE, 32'h0);
    tick();
    checkOutput("sim_ramWEN",   32'(ramWEN), 32'd1);
    checkOutput("sim_ramREN",   32'(ramREN), 32'd0);
    checkOutput("sim_ramaddr",  ramaddr,     32'h80);
    checkOutput("sim_ramstore", ramstore,    32'h1234);
    checkOutput("sim_iwait",    32'(iwait),  32'd1);
    applyStimulus(1'b1, 32'h44, 1'b0, 1'b1, 32'h80, 32'h1234, RS_ACCESS, 32'h0);
    checkOutput("sim_dwait_done", 32'(dwait), 32'd0);
    checkOutput("sim_iwait_held", 32'(iwait), 32'd1);
    tick();
    applyStimulus(1'b1, 32'h44, 1'b0, 1'b0, 32'h80, 32'h1234, RS_FREE, 32'h0);
    checkOutput("sim_bubble_en",   32'(ramREN | ramWEN), 32'd0);
    checkOutput("sim_bubble_addr", ramaddr, 32'h0);
    tick();
    checkOutput("sim_i_ramREN",  32'(ramREN), 32'd1);
    checkOutput("sim_i_ramaddr", ramaddr,     32'h44);
    applyStimulus(1'b1, 32'h44, 1'b0, 1'b0, 32'h80, 32'h1234, RS_ACCESS, 32'h11);
    checkOutput("sim_i_iwait", 32'(iwait), 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, RS_FREE, 32'h0);

    // ---- starvation: expected order D,D,D,D,I,D,D,D,D,I ----
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'h0, RS_ACCESS, 32'h0);
    for (int k = 0; k < 10; k++) begin
      tick();
      if (grantIsI[k]) begin
        checkOutput($sformatf("starve_addr_%0d", k), ramaddr, 32'h100);
        checkOutput($sformatf("starve_iwait_%0d", k), 32'(iwait), 32'd0);
      end else begin
        checkOutput($sformatf("starve_addr_%0d", k), ramaddr, 32'h200);
        checkOutput($sformatf("starve_dwait_%0d", k), 32'(dwait), 32'd0);
      end
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, RS_FREE, 32'h0);

    // ---- both data enables: write wins ----
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h300, 32'hA5A5A5A5, RS_FREE, 32'h0);
    tick();
    checkOutput("both_ramWEN",   32'(ramWEN), 32'd1);
    checkOutput("both_ramREN",   32'(ramREN), 32'd0);
    checkOutput("both_ramstore", ramstore,    32'hA5A5A5A5);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h300, 32'hA5A5A5A5, RS_ACCESS, 32'h0);
    checkOutput("both_dwait", 32'(dwait), 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, RS_FREE, 32'h0);

    // ---- ERROR, then re-grant ----
    applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, RS_FREE, 32'h0);
    tick();
    applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, RS_ERROR, 32'h0);
    checkOutput("err_iwait",  32'(iwait),  32'd1);
    checkOutput("err_ramREN", 32'(ramREN), 32'd1);
    tick();
    applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, RS_FREE, 32'h0);
    checkOutput("err_idle_ramREN", 32'(ramREN), 32'd0);
    checkOutput("err_idle_iwait",  32'(iwait),  32'd1);
    tick();
    checkOutput("err_regrant_ramREN", 32'(ramREN), 32'd1);
    checkOutput("err_regrant_addr",   ramaddr,     32'h500);
    applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, RS_ACCESS, 32'hCAFEF00D);
    checkOutput("err_done_iwait", 32'(iwait), 32'd0);
    checkOutput("err_done_iload", iload,      32'hCAFEF00D);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, RS_FREE, 32'h0);

    // ---- reset during BUSY ----
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h600, 32'h0, RS_FREE, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h600, 32'h0, RS_BUSY, 32'h0);
    checkOutput("abort_pre_ramREN", 32'(ramREN), 32'd1);
    nRST = 1'b0;
    #1;
    checkOutput("abort_ramREN",  32'(ramREN), 32'd0);
    checkOutput("abort_ramaddr", ramaddr,     32'h0);
    checkOutput("abort_dwait",   32'(dwait),  32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, RS_FREE, 32'h0);
    tick();
    nRST = 1'b1;
    tick();

    // ---- requester drops iREN mid-grant ----
    applyStimulus(1'b1, 32'h700, 1'b0, 1'b0, 32'h0, 32'h0, RS_FREE, 32'h0);
    tick();
    checkOutput("drop_pre_ramREN", 32'(ramREN), 32'd1);
    applyStimulus(1'b0, 32'h700, 1'b0, 1'b0, 32'h0, 32'h0, RS_BUSY, 32'h0);
    checkOutput("drop_ramREN", 32'(ramREN), 32'd0);
    checkOutput("drop_iwait",  32'(iwait),  32'd1);
    tick();
    applyStimulus(1'b1, 32'h700, 1'b0, 1'b0, 32'h0, 32'h0, RS_ACCESS, 32'h0);
    checkOutput("drop_idle_iwait",  32'(iwait),  32'd1);
    checkOutput("drop_idle_ramREN", 32'(ramREN), 32'd0);
    checkOutput("drop_idle_addr",   ramaddr,     32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, RS_FREE, 32'h0);
    tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
